// File: rtl/cpu_test_monitor.sv
// Run/judge harness for the cpu: sequences its reset, snoops
// signature stores, and produces a pass/fail verdict.
module cpu_test_monitor #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_CHECKS = 4,
  parameter logic [ADDR_W-1:0] SIG_BASE = 'h0000_0100,
  parameter logic [ADDR_W-1:0] DONE_ADDR = 'h0000_01FC,
  parameter int TIMEOUT = 5000,
  parameter int RESET_HOLD = 2,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       cpu_reset_n,
  input  logic                       mem_wr_sig,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_wr_data,
  input  logic [NUM_CHECKS*DATA_W-1:0] exp_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [NUM_CHECKS-1:0]      fail_mask,
  output logic                       timeout,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam int HOLD_W = 16;
  localparam int HOLD_LAST = (RESET_HOLD > 0) ? RESET_HOLD - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [HOLD_W-1:0]     hold_cnt;
  logic [NUM_CHECKS-1:0] valid;
  logic [DATA_W-1:0]     slot [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] chk_mask;

  logic [ADDR_W-1:0] off;
  logic [3:0]        slot_idx;
  logic              slot_hit;
  logic              done_wr;
  logic              to_expire;
  logic              start_ok;
  logic              hold_last;

  // Slot decode: aligned, at/after SIG_BASE, below the last slot.
  assign off      = mem_addr - SIG_BASE;
  assign slot_idx = off[5:2];
  assign slot_hit = (state == S_RUN) && mem_wr_sig
                    && (mem_addr >= SIG_BASE)
                    && (off < ADDR_W'(4 * NUM_CHECKS))
                    && (off[1:0] == 2'b00);

  assign done_wr   = (state == S_RUN) && mem_wr_sig
                     && (mem_addr == DONE_ADDR);
  assign to_expire = (state == S_RUN) && !done_wr
                     && (cycle_count == CNT_W'(TIMEOUT - 1));
  assign start_ok  = start
                     && ((state == S_IDLE) || (state == S_DONE));
  assign hold_last = (hold_cnt >= HOLD_W'(HOLD_LAST));

  always_comb begin
    chk_mask = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      chk_mask[i] = !valid[i]
        || (slot[i] != exp_data[i*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_ok) state_nxt = S_HOLD;
      S_HOLD:  if (hold_last) state_nxt = S_RUN;
      S_RUN: begin
        if (done_wr) state_nxt = S_CHECK;
        else if (to_expire) state_nxt = S_DONE;
      end
      S_CHECK: state_nxt = S_DONE;
      S_DONE:  if (start_ok) state_nxt = S_HOLD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_reset_n = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      S_IDLE:  ;
      S_HOLD:  busy = 1'b1;
      S_RUN: begin
        busy        = 1'b1;
        cpu_reset_n = 1'b1;
      end
      S_CHECK: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt    <= '0;
      valid       <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      fail_mask   <= '0;
      timeout     <= 1'b0;
    end else begin
      if (start_ok) begin
        hold_cnt    <= '0;
        valid       <= '0;
        cycle_count <= '0;
        pass        <= 1'b0;
        fail_mask   <= '0;
        timeout     <= 1'b0;
      end
      if (state == S_HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state == S_RUN) begin
        if (cycle_count != '1) begin
          cycle_count <= cycle_count + 1'b1;
        end
        for (int i = 0; i < NUM_CHECKS; i++) begin
          if (slot_hit && (slot_idx == 4'(i))) begin
            valid[i] <= 1'b1;
          end
        end
        // Abort verdict reports only which slots never arrived.
        if (to_expire) begin
          timeout   <= 1'b1;
          pass      <= 1'b0;
          fail_mask <= ~valid;
        end
      end
      if (state == S_CHECK) begin
        fail_mask <= chk_mask;
        pass      <= (chk_mask == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (slot_hit && (slot_idx == 4'(i))) begin
        slot[i] <= mem_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Directed bench for cpu_test_monitor: forced store streams,
// verdicts checked against a queue of expected results.
module tb_cpu_test_monitor;

  localparam logic [31:0] SIG  = 32'h0000_0100;
  localparam logic [31:0] DADR = 32'h0000_01FC;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cpu_reset_n;
  logic         mem_wr_sig;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wr_data;
  logic [127:0] exp_data;
  logic         busy;
  logic         done;
  logic         pass;
  logic [3:0]   fail_mask;
  logic         timeout;
  logic [31:0]  cycle_count;

  typedef struct {
    logic        pass;
    logic [3:0]  mask;
    logic        tmo;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int run_cycles = 0;

  cpu_test_monitor #(
    .NUM_CHECKS(4),
    .TIMEOUT(100),
    .RESET_HOLD(2)
  ) dut (
    .clk(clk),
    .reset(rst),
    .start(start),
    .cpu_reset_n(cpu_reset_n),
    .mem_wr_sig(mem_wr_sig),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .exp_data(exp_data),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail_mask(fail_mask),
    .timeout(timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      run_cycles++;
    end
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    mem_wr_sig  = 1'b1;
    mem_addr    = a;
    mem_wr_data = d;
    @(negedge clk);
    run_cycles++;
    mem_wr_sig  = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
  endtask

  task automatic start_run();
    int hold;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_done_clr", done, 0);
    chk("hold_mask_clr", fail_mask, 0);
    chk("hold_tmo_clr", timeout, 0);
    chk("hold_cnt_clr", cycle_count, 0);
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_reset_n) break;
      if (busy) hold++;
      @(negedge clk);
    end
    chk("hold_len", hold, 2);
    chk("run_entered", cpu_reset_n, 1);
    run_cycles = 0;
  endtask

  task automatic pop_verdict();
    exp_t e;
    for (int i = 0; i < 8 && !done; i++) @(negedge clk);
    chk("done_seen", done, 1);
    if (q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = q.pop_front();
      chk("pass", pass, e.pass);
      chk("fail_mask", fail_mask, e.mask);
      chk("timeout", timeout, e.tmo);
      chk("cycle_count", cycle_count, e.cnt);
      chk("halt_cpu", cpu_reset_n, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  task automatic finish_run(logic p, logic [3:0] m);
    q.push_back('{pass: p, mask: m, tmo: 1'b0, cnt: run_cycles + 1});
    wr(DADR, 32'hDEAD_BEEF);
    chk("check_state", done, 0);
    @(negedge clk);
    chk("latency2", done, 1);
    pop_verdict();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mem_wr_sig = 1'b0;
    mem_addr = '0;
    mem_wr_data = '0;
    exp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu", cpu_reset_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mask", fail_mask, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_cnt", cycle_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Sum-of-n style signature: all slots good
    exp_data = {32'd4, 32'd3, 32'd2, 32'd55};
    start_run();
    idle(5);
    wr(SIG, 32'd55);
    wr(SIG + 4, 32'd2);
    idle(2);
    wr(SIG + 8, 32'd3);
    wr(SIG + 12, 32'd4);
    finish_run(1'b1, 4'b0000);

    // Mismatch on slot 2, plus ignored stray stores
    exp_data = {32'd3, 32'd8, 32'd9, 32'd7};
    start_run();
    wr(SIG, 32'd7);
    wr(SIG + 4, 32'd9);
    start = 1'b1;
    wr(SIG + 8, 32'd7);
    start = 1'b0;
    chk("start_in_run", cpu_reset_n, 1);
    wr(SIG + 12, 32'd3);
    wr(SIG + 1, 32'hBAD);
    wr(SIG + 32'h40, 32'hBAD);
    wr(32'h0000_0000, 32'hBAD);
    finish_run(1'b0, 4'b0100);

    // Last write wins; DONE exactly on count 99
    exp_data = {32'd13, 32'd12, 32'd11, 32'd2};
    start_run();
    wr(SIG, 32'd1);
    wr(SIG, 32'd2);
    wr(SIG + 4, 32'd11);
    wr(SIG + 8, 32'd12);
    wr(SIG + 12, 32'd13);
    idle(99 - run_cycles);
    chk("pre_limit", cycle_count, 99);
    finish_run(1'b1, 4'b0000);

    // Restart from DONE: captures cleared, HOLD stores ignored
    mem_wr_sig  = 1'b1;
    mem_addr    = SIG + 4;
    mem_wr_data = 32'd11;
    start_run();
    mem_wr_sig  = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    idle(3);
    finish_run(1'b0, 4'b1111);

    // Timeout with no DONE write
    start_run();
    q.push_back('{pass: 1'b0, mask: 4'b1111, tmo: 1'b1, cnt: 32'd100});
    idle(99);
    chk("tmo_not_yet", done, 0);
    idle(1);
    chk("tmo_exact", done, 1);
    pop_verdict();

    // Asynchronous reset in mid-run, then a clean rerun
    start_run();
    wr(SIG, 32'd2);
    idle(4);
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu", cpu_reset_n, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_mask", fail_mask, 0);
    chk("arst_tmo", timeout, 0);
    chk("arst_cnt", cycle_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    start_run();
    wr(SIG + 4, 32'd11);
    wr(SIG + 8, 32'd12);
    wr(SIG + 12, 32'd13);
    finish_run(1'b0, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_test_monitor.md
Name: cpu_test_monitor

Overview:
- Synthesizable self-check harness that runs a program on the cpu and judges the result. Parametrised successor to the fixed-delay, single-register check in the cpu bench.
- Sequences the cpu's reset_n and counts cycles. Snoops the cpu→ram write bus and captures NUM_CHECKS signature words written to a memory-mapped region.
- Ends the run on a write to a DONE address or on a cycle timeout, then compares every slot against expected values.
- Sits beside cpu/ram/rom in benches and on FPGA; pass/fail can drive LEDs.

Parameters:
- ADDR_W, 32, width of mem_addr.
- DATA_W, 32, width of data words.
- NUM_CHECKS, 4, number of signature slots (1..16).
- SIG_BASE, 32'h0000_0100, byte address of slot 0; slot i is at SIG_BASE+4*i.
- DONE_ADDR, 32'h0000_01FC, a write here ends the run.
- TIMEOUT, 5000, maximum RUN cycles before abort.
- RESET_HOLD, 2, cycles cpu_reset_n is held low after start.
- CNT_W, 32, width of cycle_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset of this block.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- cpu_reset_n  out  1  drives cpu/rom/ram reset_n; 1 only in RUN.
- mem_wr_sig  in  1  cpu store strobe.
- mem_addr  in  ADDR_W  cpu data address.
- mem_wr_data  in  DATA_W  cpu store data.
- exp_data  in  NUM_CHECKS*DATA_W  expected signatures; slot i is bits [i*DATA_W +: DATA_W]; sampled in CHECK.
- busy  out  1  high in HOLD, RUN, CHECK.
- done  out  1  high in DONE.
- pass  out  1  verdict; meaningful only when done=1.
- fail_mask  out  NUM_CHECKS  bit i=1 if slot i is missing or mismatched.
- timeout  out  1  run aborted by TIMEOUT.
- cycle_count  out  CNT_W  RUN cycles elapsed; frozen after RUN.

Behaviour:
- Reset: asynchronous, active-high. State=IDLE, cpu_reset_n=0, busy=0, done=0, pass=0, fail_mask=0, timeout=0, cycle_count=0, all slot valid bits=0. Reset mid-run aborts immediately to these values.
- FSM states: IDLE, HOLD, RUN, CHECK, DONE.
- IDLE→HOLD on start. Entering HOLD clears slot valid bits, cycle_count, pass, fail_mask, timeout and done.
- HOLD: cpu_reset_n=0 for exactly RESET_HOLD cycles, then RUN.
- RUN: cpu_reset_n=1; cycle_count increments by 1 every cycle.
- Capture rule, RUN only, when mem_wr_sig=1:
  - Write to a valid slot address (mem_addr = SIG_BASE+4*i, i < NUM_CHECKS): slot i ← mem_wr_data, valid_i ← 1. Repeated writes to a slot keep the last value.
  - Write with mem_addr[1:0] != 0 is ignored.
  - Write inside the region but i ≥ NUM_CHECKS is ignored.
  - Any other address is ignored.
- RUN→CHECK on a write to DONE_ADDR. The data of that write is ignored.
- RUN→DONE with timeout=1 when cycle_count reaches TIMEOUT-1 and no DONE write occurs that cycle. The count on exit is TIMEOUT; pass=0; fail_mask bit i = !valid_i; no compare is done.
- A DONE write and the timeout in the same cycle: the DONE write wins (goes to CHECK, timeout=0).
- CHECK: exactly one cycle. fail_mask[i] = !valid_i || slot_i != exp_data slot i. pass = (fail_mask==0). Then DONE.
- Latency: verdict appears 2 cycles after the DONE write (CHECK, then DONE registered).
- DONE: cpu_reset_n=0 (halts cpu); all outputs held. start→HOLD begins a fresh run.
- start is ignored in HOLD, RUN and CHECK.
- mem_wr_sig is ignored outside RUN.
- cycle_count saturates at its maximum value and never wraps.

Test Plan:
- Recursive sum-of-n program stores 55 to SIG_BASE, then writes DONE_ADDR; exp slot0=55, NUM_CHECKS=1 → done=1, pass=1, fail_mask=0, timeout=0, cycle_count equal to the cpu's run length.
- Forced stimulus: writes slot0=7, slot1=9, slot2=7, slot3=3, then DONE; exp slots 0..3 = 7,9,8,3 → pass=0, fail_mask=4'b0100.
- Never write DONE_ADDR, TIMEOUT=100 → done after exactly 100 RUN cycles, timeout=1, cycle_count=100, pass=0, fail_mask=4'b1111 when no slots were written.
- DONE write on the same cycle the count reaches 99 (TIMEOUT=100) → timeout=0 and the verdict is taken from the compare.
- Edge cases:
  - Misaligned write to SIG_BASE+1 is ignored.
  - Write to SIG_BASE+0x40 is ignored.
  - Writes to slot0 of 1 then 2 keep 2; exp=2 → pass=1.
- Assert reset in mid-RUN → cpu_reset_n=0 and all outputs 0 asynchronously. A later start reruns cleanly; start pulsed in DONE reruns with cleared captures; start pulsed during RUN has no effect.
